dla_ddr_feed_scheduler: RTL and testbench
=========================================

# dla_ddr_feed_scheduler

Sequences the DLA's per-lane DDR write-enable inputs, which sit alongside the 16-bit DDR data lanes driven by the random-number sources in the DLA random-input wrapper. On a start command, it grants fixed-length write bursts to the enabled lanes in round-robin order for a programmed number of rounds. It then waits for the DLA's `o_valid` and reports completion. It replaces free-running testbench `wen` stimulus with a deterministic, backpressure-aware feed.

## Interface
- `NUM_LANES`, 12: DDR lanes, ordered {0_0,0_1,1_0,…,5_1}; lane index = 2*i+j.
- `BURST_LEN`, 8: write beats per lane grant; must be ≥1.
- `ROUNDS_W`, 8: width of the round-count input.
- `TIMEOUT`, 1024: drain timeout in cycles; only used with `DLA_SCHED_TIMEOUT_EN`.
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: **asynchronous, active-high** reset.
- `i_start` in 1: start pulse; sampled only in IDLE.
- `i_lane_mask` in NUM_LANES: lane enables, latched on accepted start.
- `i_rounds` in ROUNDS_W: full round-robin passes, latched on accepted start.
- `i_lane_ready` in NUM_LANES: per-lane sink ready (backpressure).
- `i_dla_valid` in 1: DLA `o_valid`.
- `o_ddr_wen` out NUM_LANES: one-hot or zero write enables, to DLA `i_ddr_wen_*`.
- `o_lane_idx` out $clog2(NUM_LANES): current granted lane.
- `o_busy` out 1: high in FEED and DRAIN.
- `o_done` out 1: one-cycle completion pulse.
- `o_timeout` out 1: sticky drain-timeout flag.
- `o_words_issued` out 32: count of write beats issued since the last accepted start; saturates at 2^32-1.

## Operation
- **FSM states:** IDLE, FEED, DRAIN, DONE.
- **IDLE:**
  - `i_start`=1 with nonzero mask and nonzero rounds: latch mask and rounds, clear the word counter and `o_timeout`, set the lane pointer to the lowest set mask bit, clear the beat and round counters, go to FEED.
  - `i_start`=1 with mask==0 or rounds==0: go to DONE; zero words issued.
- **FEED:**
  - `o_ddr_wen[lane]` = `i_lane_ready[lane]`; all other bits are 0. This output is combinational from registered state and ready.
  - Each asserted beat increments the beat counter and `o_words_issued`.
  - A deasserted ready stalls that lane; there is no skipping and no timeout.
  - On the beat where beat==BURST_LEN-1: clear beat and advance the pointer to the next set mask bit above the current one, circularly.
  - Wrapping from the highest set bit to the lowest set bit completes a round. When the completed-round count equals the latched rounds, go to DRAIN instead of advancing.
  - A single-bit mask stays on the same lane and counts a round per burst.
- **DRAIN:**
  - `o_ddr_wen`=0.
  - `i_dla_valid`=1 goes to DONE.
  - `i_dla_valid` during IDLE or FEED is ignored.
- **DONE:** `o_done`=1 for exactly one cycle, then IDLE.
- `i_start` outside IDLE is ignored, and latched mask and rounds are not affected.
- `i_lane_mask` and `i_rounds` changes after start have no effect.

## Timing
- **Reset values:**
  - State IDLE, `o_ddr_wen`=0, `o_lane_idx`=0.
  - `o_busy`=0, `o_done`=0, `o_timeout`=0, `o_words_issued`=0.
  - All counters 0.
- **Reset mid-operation:** `o_ddr_wen` drops asynchronously; no done pulse is generated.
- **Start latency:** `i_start` sampled at edge N; `o_busy`=1 and the first possible `o_ddr_wen` in cycle N+1.
- **Lane switches have zero bubble:** lane k's last beat is in cycle t, the next lane's first possible beat is in cycle t+1.
- **Feed duration:** with all lanes ready, P = popcount(mask) and R = rounds, FEED lasts exactly P·R·BURST_LEN cycles.
- **Drain to done:** `i_dla_valid` sampled high at edge M gives `o_done`=1 in cycle M+1 and IDLE in M+2.
- **Zero-work start:** `o_done` in cycle N+1.
- **Back-to-back runs:** a new start is accepted in the first IDLE cycle after DONE.

## Configuration
- `DLA_SCHED_TIMEOUT_EN`:
  - **Defined:** a DRAIN cycle counter clears on DRAIN entry. If TIMEOUT cycles elapse without `i_dla_valid`, go to DONE and set `o_timeout` (held until the next accepted start). Valid and timeout in the same cycle count as valid, and `o_timeout` stays 0.
  - **Undefined:** DRAIN waits indefinitely, and `o_timeout` is tied to 0.

## Test plan
- **Basic run:** mask=0xFFF, rounds=1, all ready, valid 5 cycles after DRAIN entry → 96 `wen` beats, lanes 0..11 in order, 8 each; `o_words_issued`=96; `o_done` one cycle.
- **Sparse mask:** mask=0x821, rounds=2 → lane order 0,5,11,0,5,11, each an 8-beat burst; 48 beats total; no gap between lanes.
- **Backpressure:** lane 3 ready low for 4 cycles mid-burst → `wen` zero for those 4 cycles; lane 3 still gets exactly 8 beats; FEED lengthened by 4.
- **Degenerate start:** mask=0 (or rounds=0) → `o_done` next cycle, `o_ddr_wen` never asserted, `o_words_issued`=0.
- **Async reset:** reset asserted in FEED at beat 3 of lane 2 → `wen`=0 immediately; all outputs at reset values; no `o_done`; a subsequent start behaves normally.
- **Timeout (`DLA_SCHED_TIMEOUT_EN`, TIMEOUT=16):** valid never asserted → `o_done` with `o_timeout`=1 exactly 16 cycles after DRAIN entry; the next start clears `o_timeout`.

Source files
------------

// File: rtl/dla_ddr_feed_scheduler.sv
// dla_ddr_feed_scheduler
//   Drives the DLA per-lane DDR write enables with a deterministic feed.
//   On start it grants BURST_LEN-beat write bursts to the enabled lanes in
//   round-robin order for a programmed number of passes. It then waits for
//   the DLA valid and pulses done.
//
//   Optional feature macro: DLA_SCHED_TIMEOUT_EN
//     defined   -> DRAIN gives up after TIMEOUT cycles and sets o_timeout
//     undefined -> DRAIN waits indefinitely, o_timeout tied low
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   i_start         start pulse, only honoured in IDLE
//   i_lane_mask     lane enables, latched on accepted start
//   i_rounds        round-robin passes, latched on accepted start
//   i_lane_ready    per-lane sink ready (backpressure)
//   i_dla_valid     DLA o_valid, ends DRAIN
//   o_ddr_wen       one-hot or zero write enables
//   o_lane_idx      currently granted lane
//   o_busy          high in FEED and DRAIN
//   o_done          one-cycle completion pulse
//   o_timeout       sticky drain-timeout flag
//   o_words_issued  beats issued since last accepted start, saturating
//
// state | meaning
// IDLE  | waiting for start
// FEED  | granting bursts to enabled lanes round-robin
// DRAIN | feed finished, waiting for DLA valid
// DONE  | one-cycle completion pulse
module dla_ddr_feed_scheduler #(
  parameter int NUM_LANES = 12,
  parameter int BURST_LEN = 8,
  parameter int ROUNDS_W  = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [NUM_LANES-1:0]         i_lane_mask,
  input  logic [ROUNDS_W-1:0]          i_rounds,
  input  logic [NUM_LANES-1:0]         i_lane_ready,
  input  logic                         i_dla_valid,
  output logic [NUM_LANES-1:0]         o_ddr_wen,
  output logic [$clog2(NUM_LANES)-1:0] o_lane_idx,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_timeout,
  output logic [31:0]                  o_words_issued
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if (BURST_LEN < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("dla_ddr_feed_scheduler: BURST_LEN and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] mask_q;
  logic [ROUNDS_W-1:0]  rounds_q, round_q;
  logic [LANE_W-1:0]    lane_q, lane_nxt;
  logic [BEAT_W-1:0]    beat_q;
  logic [31:0]          words_q;
  logic                 start_ok, beat_fire, burst_last, round_wrap, last_round, feed_end;

  function automatic logic [LANE_W-1:0] lowest_set(input logic [NUM_LANES-1:0] m);
    lowest_set = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (m[i]) lowest_set = LANE_W'(i);
  endfunction

  // Nearest set bit above cur, circularly; cur itself when it is the only one.
  function automatic logic [LANE_W-1:0] next_set(input logic [NUM_LANES-1:0] m,
                                                 input logic [LANE_W-1:0]    cur);
    int idx;
    next_set = cur;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = int'(cur) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (m[idx]) next_set = LANE_W'(idx);
    end
  endfunction

  assign start_ok   = i_start && (|i_lane_mask) && (|i_rounds);
  assign beat_fire  = (state_q == FEED) && i_lane_ready[lane_q];
  assign burst_last = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign lane_nxt   = next_set(mask_q, lane_q);
  // Moving to an index not above the current one closes a round-robin pass.
  assign round_wrap = (lane_nxt <= lane_q);
  assign last_round = (({1'b0, round_q} + (ROUNDS_W + 1)'(1)) == {1'b0, rounds_q});
  assign feed_end   = beat_fire && burst_last && round_wrap && last_round;

`ifdef DLA_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             timeout_q;

  // Down-counter preloaded outside DRAIN; reaching zero marks the last DRAIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tmo_q <= '0;
    else if (state_q != DRAIN) tmo_q <= TMO_W'(TIMEOUT - 1);
    else if (tmo_q != '0)      tmo_q <= tmo_q - TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            timeout_q <= 1'b0;
    else if (state_q == IDLE && start_ok) timeout_q <= 1'b0;
    else if (tmo_hit)                   timeout_q <= 1'b1;
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    o_ddr_wen = '0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
`ifdef DLA_SCHED_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state_q)
      IDLE:  if (i_start) state_d = start_ok ? FEED : DONE;
      FEED: begin
        o_busy            = 1'b1;
        o_ddr_wen[lane_q] = i_lane_ready[lane_q];
        if (feed_end) state_d = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (i_dla_valid) state_d = DONE;
`ifdef DLA_SCHED_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = DONE;
          tmo_hit = 1'b1;
        end
`endif
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      rounds_q <= '0;
      round_q  <= '0;
      lane_q   <= '0;
      beat_q   <= '0;
      words_q  <= '0;
    end else if (state_q == IDLE) begin
      if (start_ok) begin
        mask_q   <= i_lane_mask;
        rounds_q <= i_rounds;
        round_q  <= '0;
        lane_q   <= lowest_set(i_lane_mask);
        beat_q   <= '0;
        words_q  <= '0;
      end else if (i_start) begin
        words_q  <= '0;
      end
    end else if (beat_fire) begin
      if (words_q != '1) words_q <= words_q + 32'd1;
      if (burst_last) begin
        beat_q <= '0;
        if (round_wrap && !last_round) round_q <= round_q + ROUNDS_W'(1);
        // On the final beat the pointer stays put; FEED is ending.
        if (!(round_wrap && last_round)) lane_q <= lane_nxt;
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  assign o_lane_idx     = lane_q;
  assign o_words_issued = words_q;

endmodule

// File: tb/tb_dla_ddr_feed_scheduler.sv
// tb_dla_ddr_feed_scheduler
//   Directed bench for dla_ddr_feed_scheduler. Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge, or
//   mid-cycle for the asynchronous reset checks.
//   With DLA_SCHED_TIMEOUT_EN defined the drain-timeout scenario is added.
module tb_dla_ddr_feed_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [11:0] i_lane_mask = '0;
  logic [7:0]  i_rounds = '0;
  logic [11:0] i_lane_ready = '0;
  logic        i_dla_valid = 1'b0;
  logic [11:0] o_ddr_wen;
  logic [3:0]  o_lane_idx;
  logic        o_busy, o_done, o_timeout;
  logic [31:0] o_words_issued;

  int vectors = 0;
  int miscompares = 0;

  dla_ddr_feed_scheduler #(
    .NUM_LANES(12), .BURST_LEN(8), .ROUNDS_W(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_lane_mask(i_lane_mask),
    .i_rounds(i_rounds), .i_lane_ready(i_lane_ready), .i_dla_valid(i_dla_valid),
    .o_ddr_wen(o_ddr_wen), .o_lane_idx(o_lane_idx), .o_busy(o_busy),
    .o_done(o_done), .o_timeout(o_timeout), .o_words_issued(o_words_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full run: start, FEED with optional stall, DRAIN for valid_delay
  // cycles, then valid and the done pulse. Caller sits 1 unit after an edge.
  task automatic run_feed(input string tag, input logic [11:0] mask, input int rounds,
                          input int stall_at, input int stall_len,
                          input int exp_cycles, input int exp_words, input int valid_delay);
    int q[$];
    int cycles, popped, stall_left;
    logic [11:0] exp_wen;
    for (int r = 0; r < rounds; r++)
      for (int l = 0; l < 12; l++)
        if (mask[l])
          for (int b = 0; b < 8; b++) q.push_back(l);

    i_start      = 1'b1;
    i_lane_mask  = mask;
    i_rounds     = 8'(rounds);
    i_lane_ready = 12'hFFF;
    @(negedge clk);
    chk({tag, " idle_busy"}, o_busy, 1'b0);
    chk({tag, " idle_done"}, o_done, 1'b0);
    next_cycle();
    i_start     = 1'b0;
    i_lane_mask = 12'h000;
    i_rounds    = 8'd0;

    cycles = 0; popped = 0; stall_left = stall_len;
    while (q.size() > 0 && cycles < 400) begin
      i_start     = (cycles == 5);
      i_dla_valid = (cycles == 2);
      if (popped == stall_at && stall_left > 0) begin
        i_lane_ready = ~(12'b1 << q[0]);
        stall_left--;
      end else begin
        i_lane_ready = 12'hFFF;
      end
      @(negedge clk);
      exp_wen = i_lane_ready[q[0]] ? (12'b1 << q[0]) : 12'h000;
      chk({tag, " wen"}, o_ddr_wen, exp_wen);
      chk({tag, " lane_idx"}, o_lane_idx, q[0]);
      if (!o_busy) chk({tag, " feed_busy"}, o_busy, 1'b1);
      if (exp_wen != 0) begin
        void'(q.pop_front());
        popped++;
      end
      cycles++;
      next_cycle();
    end
    i_start      = 1'b0;
    i_dla_valid  = 1'b0;
    i_lane_ready = 12'hFFF;
    chk({tag, " feed_cycles"}, cycles, exp_cycles);

    for (int i = 0; i < valid_delay; i++) begin
      @(negedge clk);
      chk({tag, " drain_wen"}, o_ddr_wen, 12'h000);
      chk({tag, " drain_busy"}, o_busy, 1'b1);
      chk({tag, " drain_done"}, o_done, 1'b0);
      next_cycle();
    end
    i_dla_valid = 1'b1;
    @(negedge clk);
    chk({tag, " valid_busy"}, o_busy, 1'b1);
    next_cycle();
    i_dla_valid = 1'b0;
    @(negedge clk);
    chk({tag, " done"}, o_done, 1'b1);
    chk({tag, " done_busy"}, o_busy, 1'b0);
    chk({tag, " words"}, o_words_issued, exp_words);
    chk({tag, " timeout"}, o_timeout, 1'b0);
    next_cycle();
  endtask

  task automatic zero_start(input string tag, input logic [11:0] mask, input logic [7:0] rounds);
    i_start     = 1'b1;
    i_lane_mask = mask;
    i_rounds    = rounds;
    @(negedge clk);
    chk({tag, " pre_done"}, o_done, 1'b0);
    next_cycle();
    i_start = 1'b0;
    @(negedge clk);
    chk({tag, " done"}, o_done, 1'b1);
    chk({tag, " wen"}, o_ddr_wen, 12'h000);
    chk({tag, " busy"}, o_busy, 1'b0);
    chk({tag, " words"}, o_words_issued, 32'd0);
    next_cycle();
    @(negedge clk);
    chk({tag, " done_clear"}, o_done, 1'b0);
    chk({tag, " wen_idle"}, o_ddr_wen, 12'h000);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst wen", o_ddr_wen, 12'h000);
    chk("rst lane_idx", o_lane_idx, 4'd0);
    chk("rst busy", o_busy, 1'b0);
    chk("rst done", o_done, 1'b0);
    chk("rst timeout", o_timeout, 1'b0);
    chk("rst words", o_words_issued, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_feed("basic", 12'hFFF, 1, -1, 0, 96, 96, 5);
    run_feed("sparse", 12'h821, 2, -1, 0, 48, 48, 0);
    // Lane 3 beat 3 is overall beat 27 of a full-mask single pass.
    run_feed("bp", 12'hFFF, 1, 27, 4, 100, 96, 2);
    zero_start("zmask", 12'h000, 8'd3);
    zero_start("zrounds", 12'hFFF, 8'd0);

    // Asynchronous reset in FEED at beat 3 of lane 2 (overall beat 19).
    i_start = 1'b1; i_lane_mask = 12'hFFF; i_rounds = 8'd1; i_lane_ready = 12'hFFF;
    next_cycle();
    i_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("arst pre_wen", o_ddr_wen, 12'h004);
    chk("arst pre_lane", o_lane_idx, 4'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst wen", o_ddr_wen, 12'h000);
    chk("arst busy", o_busy, 1'b0);
    chk("arst done", o_done, 1'b0);
    chk("arst lane_idx", o_lane_idx, 4'd0);
    chk("arst words", o_words_issued, 32'd0);
    chk("arst timeout", o_timeout, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("arst no_done", o_done, 1'b0);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_feed("single", 12'h010, 3, -1, 0, 24, 24, 1);

`ifdef DLA_SCHED_TIMEOUT_EN
    i_start = 1'b1; i_lane_mask = 12'h001; i_rounds = 8'd1; i_lane_ready = 12'hFFF;
    next_cycle();
    i_start = 1'b0;
    repeat (8) next_cycle();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo wait_done", o_done, 1'b0);
      chk("tmo wait_busy", o_busy, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk("tmo done", o_done, 1'b1);
    chk("tmo flag", o_timeout, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("tmo sticky", o_timeout, 1'b1);
    next_cycle();
    run_feed("tmo_clear", 12'h001, 1, -1, 0, 8, 8, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
